id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk input 1 -- clock; all state updates on posedge.
REQ-002 SHALL have port rst input 1 -- reset, asynchronous, active-high.
REQ-003 SHALL have ports stall input 1 (hold stage), flush input 1 (insert bubble), in_valid input 1 (ID holds an instruction).
REQ-004 SHALL have ports in_opcode input 6, in_funct input 6, in_shamt input 5, in_imm input 16 -- decoded instruction fields.
REQ-005 SHALL have ports in_rs, in_rt, in_rd input 5 each; in_rd1, in_rd2 input 32 each -- register-file read data.
REQ-006 SHALL have ports mem_regwrite input 1, mem_dst input 5, mem_res input 32, wb_regwrite input 1, wb_dst input 5, wb_res input 32 -- forwarding sources.
REQ-007 SHALL have ports SrcAE output 32, SrcBE output 32, ALUctr output 4 -- registered ALU operands and control.
REQ-008 SHALL have ports ex_valid output 1, ex_regwrite output 1, ex_dst output 5, ex_wdata output 32 (store data), illegal output 1.

Function
REQ-009 Stage SHALL be one register deep: fields captured at posedge appear on outputs same cycle, stable before the ALU's negedge sample.
REQ-010 R-type (opcode 000000) funct map: 100000/100001->0000, 100010/100011->0001, 100100->0010, 100111->0011, 100101->0100, 100110->0101, 000000->0110, 000010->0111, 000011->1000, 000100->0110, 000110->0111, 000111->1000, 101010->1001.
REQ-011 I-type map: 001000/001001->0000, 001100->0010, 001101->0100, 001110->0101, 001010->1001, 100011/101011->0000, 000100->0001, 000101->1010.
REQ-012 Shift encoding: SrcAE = shift amount, SrcBE = value; sll/srl/sra take SrcAE = {27'b0,in_shamt}; variable shifts take SrcAE = rs operand.
REQ-013 Immediate: andi/ori/xori zero-extend in_imm; all other I-type sign-extend; SrcBE = extended imm except beq/bne (SrcBE = rt operand).
REQ-014 ex_dst = in_rd for R-type, in_rt for I-type writers; ex_regwrite = 0 for sw/beq/bne/illegal, else 1 when captured valid.
REQ-015 Unmapped opcode/funct with in_valid=1 SHALL capture ALUctr=1111, illegal=1, ex_regwrite=0, ex_valid=1.
REQ-016 Forwarding per operand: source register 0 never forwarded; match mem_dst with mem_regwrite=1 wins; else match wb_dst with wb_regwrite=1; else in_rd1/in_rd2.
REQ-017 ex_wdata SHALL carry the forwarded rt operand for every instruction.
REQ-018 stall=1 SHALL hold every output unchanged.
REQ-019 flush=1 (priority over stall) or in_valid=0 SHALL capture a bubble: ex_valid=0, ex_regwrite=0, illegal=0, ALUctr=0000, SrcAE=SrcBE=ex_wdata=0, ex_dst=0.

Reset
REQ-020 rst=1 SHALL immediately clear every output to 0 (ALUctr=0000), independent of clk, including mid-stall.
REQ-021 First posedge after rst deasserts SHALL capture normally.

Configuration
REQ-022 Macro ID_EX_FORWARD_EN defined: REQ-016 forwarding active.
REQ-023 Macro ID_EX_FORWARD_EN undefined: operands taken from in_rd1/in_rd2 only; mem_*/wb_* inputs SHALL be ignored; ports retained.

Structure
REQ-024 Shared package SHALL hold ALUctr codes (0000-1010, 1111 illegal), opcode and funct constants, and the 32-bit word width.
REQ-025 Forwarding selection SHALL be sub-module fwd_mux, instantiated once per operand.

Verification
REQ-026 add r3,r1,r2, rd1=5, rd2=7 -> ALUctr=0000, SrcAE=5, SrcBE=7, ex_dst=3, ex_regwrite=1.
REQ-027 sra rd=4,rt=2,shamt=3, rd2=0x80000000 -> ALUctr=1000, SrcAE=3, SrcBE=0x80000000.
REQ-028 ori rt=5, imm=0xFFFF -> SrcBE=0x0000FFFF; addi same imm -> SrcBE=0xFFFFFFFF.
REQ-029 rs=1 with mem_dst=1, mem_res=0xAA and wb_dst=1, wb_res=0xBB, both regwrite -> SrcAE=0xAA; rs=0 with mem_dst=0 -> SrcAE=in_rd1.
REQ-030 stall=1 two cycles then flush=1 with stall=1 -> outputs held, then ex_valid=0, ALUctr=0000; opcode 111111 -> ALUctr=1111, illegal=1.
REQ-031 rst pulse between clock edges while ex_valid=1 -> all outputs 0 before next posedge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: word width, ALU control
// codes, MIPS opcode/funct constants and the two decode lookup functions.
package id_ex_stage_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_AND     = 4'b0010,
    ALU_NOR     = 4'b0011,
    ALU_OR      = 4'b0100,
    ALU_XOR     = 4'b0101,
    ALU_SLL     = 4'b0110,
    ALU_SRL     = 4'b0111,
    ALU_SRA     = 4'b1000,
    ALU_SLT     = 4'b1001,
    ALU_SNE     = 4'b1010,
    ALU_ILLEGAL = 4'b1111
  } alu_ctr_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  function automatic alu_ctr_e rtype_ctr(input logic [5:0] funct);
    case (funct)
      F_ADD, F_ADDU:  return ALU_ADD;
      F_SUB, F_SUBU:  return ALU_SUB;
      F_AND:          return ALU_AND;
      F_NOR:          return ALU_NOR;
      F_OR:           return ALU_OR;
      F_XOR:          return ALU_XOR;
      F_SLL, F_SLLV:  return ALU_SLL;
      F_SRL, F_SRLV:  return ALU_SRL;
      F_SRA, F_SRAV:  return ALU_SRA;
      F_SLT:          return ALU_SLT;
      default:        return ALU_ILLEGAL;
    endcase
  endfunction

  function automatic alu_ctr_e itype_ctr(input logic [5:0] opcode);
    case (opcode)
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: return ALU_ADD;
      OP_ANDI:                         return ALU_AND;
      OP_ORI:                          return ALU_OR;
      OP_XORI:                         return ALU_XOR;
      OP_SLTI:                         return ALU_SLT;
      OP_BEQ:                          return ALU_SUB;
      OP_BNE:                          return ALU_SNE;
      default:                         return ALU_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: MEM result beats WB result beats register file;
// register 0 is never forwarded. fwd_en=0 always returns the register file data.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic              fwd_en,
  input  logic [4:0]        src,
  input  logic [WORD_W-1:0] rf_data,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_dst,
  input  logic [WORD_W-1:0] mem_res,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_dst,
  input  logic [WORD_W-1:0] wb_res,
  output logic [WORD_W-1:0] operand
);

  always_comb begin
    // NOTE: assign a default before any branch so every path drives operand and no latch is inferred.
    operand = rf_data;
    if (fwd_en && (src != 5'd0)) begin
      if (mem_regwrite && (mem_dst == src)) begin
        operand = mem_res;
      end else if (wb_regwrite && (wb_dst == src)) begin
        operand = wb_res;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode to ALU control and operand selection.
// Define ID_EX_FORWARD_EN to enable MEM/WB forwarding into both operands.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [WORD_W-1:0] in_rd1,
  input  logic [WORD_W-1:0] in_rd2,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_dst,
  input  logic [WORD_W-1:0] mem_res,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_dst,
  input  logic [WORD_W-1:0] wb_res,
  output logic [WORD_W-1:0] SrcAE,
  output logic [WORD_W-1:0] SrcBE,
  output logic [3:0]        ALUctr,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic [4:0]        ex_dst,
  output logic [WORD_W-1:0] ex_wdata,
  output logic              illegal
);

  logic fwd_en;
`ifdef ID_EX_FORWARD_EN
  assign fwd_en = 1'b1;
`else
  assign fwd_en = 1'b0;
`endif

  logic [WORD_W-1:0] rs_op, rt_op;

  fwd_mux u_fwd_a (
    .fwd_en, .src(in_rs), .rf_data(in_rd1),
    .mem_regwrite, .mem_dst, .mem_res,
    .wb_regwrite, .wb_dst, .wb_res,
    .operand(rs_op)
  );

  fwd_mux u_fwd_b (
    .fwd_en, .src(in_rt), .rf_data(in_rd2),
    .mem_regwrite, .mem_dst, .mem_res,
    .wb_regwrite, .wb_dst, .wb_res,
    .operand(rt_op)
  );

  alu_ctr_e          ctr;
  logic              is_rtype, is_branch, zero_ext;
  logic [WORD_W-1:0] imm_ext, nxt_a, nxt_b;
  logic [4:0]        nxt_dst;
  logic              nxt_we, nxt_ill;

  always_comb begin
    is_rtype  = (in_opcode == OP_RTYPE);
    is_branch = (in_opcode == OP_BEQ) || (in_opcode == OP_BNE);
    zero_ext  = (in_opcode inside {OP_ANDI, OP_ORI, OP_XORI});
    imm_ext   = zero_ext ? {{(WORD_W-16){1'b0}}, in_imm}
                         : {{(WORD_W-16){in_imm[15]}}, in_imm};
    ctr       = is_rtype ? rtype_ctr(in_funct) : itype_ctr(in_opcode);
    nxt_a     = rs_op;
    nxt_b     = rt_op;
    nxt_dst   = 5'd0;
    nxt_we    = 1'b0;
    nxt_ill   = 1'b0;
    if (ctr == ALU_ILLEGAL) begin
      nxt_ill = 1'b1;
    end else if (is_rtype) begin
      // Constant shifts carry the amount in SrcAE; variable shifts use rs.
      if (in_funct inside {F_SLL, F_SRL, F_SRA}) nxt_a = {{(WORD_W-5){1'b0}}, in_shamt};
      nxt_dst = in_rd;
      nxt_we  = 1'b1;
    end else begin
      if (!is_branch) nxt_b = imm_ext;
      if (!is_branch && (in_opcode != OP_SW)) begin
        nxt_dst = in_rt;
        nxt_we  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      SrcAE       <= '0;
      SrcBE       <= '0;
      ALUctr      <= ALU_ADD;
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_dst      <= 5'd0;
      ex_wdata    <= '0;
      illegal     <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      SrcAE       <= '0;
      SrcBE       <= '0;
      ALUctr      <= ALU_ADD;
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_dst      <= 5'd0;
      ex_wdata    <= '0;
      illegal     <= 1'b0;
    end else if (!stall) begin
      SrcAE       <= nxt_a;
      SrcBE       <= nxt_b;
      ALUctr      <= ctr;
      ex_valid    <= 1'b1;
      ex_regwrite <= nxt_we;
      ex_dst      <= nxt_dst;
      ex_wdata    <= rt_op;
      illegal     <= nxt_ill;
    end
  end

endmodule
